// File: rtl/hex_serial_comparator_pkg.sv
// Shared types for the digit-serial hex comparator.
// State encoding, result bundle and cascade resolution.
package hex_comp_pkg;

  localparam int DIG_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

  // Tie-break for equal operands; ei wins over li, li over gi.
  function automatic cmp_res_t resolve_cascade(
    input logic ei,
    input logic li,
    input logic gi
  );
    cmp_res_t r;
    r = '0;
    if (ei) begin
      r.eq = 1'b1;
    end else if (li) begin
      r.lt = 1'b1;
    end else if (gi) begin
      r.gt = 1'b1;
    end else begin
      r.eq = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_serial_comparator_if.sv
// Request/result bundle for the serial comparator.
// master drives the request, slave returns status and result.
interface hex_serial_comparator_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ei;
  logic             li;
  logic             gi;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;

  modport master (
    output start, a, b, ei, li, gi,
    input  busy, done, gt, lt, eq
  );

  modport slave (
    input  start, a, b, ei, li, gi,
    output busy, done, gt, lt, eq
  );

endinterface

// File: rtl/hex_serial_comparator_nibble_cmp.sv
// Combinational 4-bit digit comparator.
// signed_msb flips bit 3 so the MSB digit orders as two's complement.
module nibble_cmp
  import hex_comp_pkg::*;
(
  input  logic [DIG_W-1:0] a_dig,
  input  logic [DIG_W-1:0] b_dig,
  input  logic             signed_msb,
  output logic             gt,
  output logic             lt
);

  logic [DIG_W-1:0] a_x;
  logic [DIG_W-1:0] b_x;

  // Bias the sign bit, then a plain unsigned compare does the rest.
  always_comb begin
    a_x = {a_dig[DIG_W-1] ^ signed_msb, a_dig[DIG_W-2:0]};
    b_x = {b_dig[DIG_W-1] ^ signed_msb, b_dig[DIG_W-2:0]};
    gt  = (a_x > b_x);
    lt  = (a_x < b_x);
  end

endmodule

// File: rtl/hex_serial_comparator.sv
// Digit-serial hex magnitude comparator, MSB digit first.
// Define HEX_COMP_SIGNED_EN for two's-complement operands.
module hex_serial_comparator
  import hex_comp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst,
  hex_serial_comparator_if.slave  bus
);

  localparam int NDIG  = WIDTH / DIG_W;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIG - 1);

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [WIDTH-1:0]           a_q, a_d;
  logic [WIDTH-1:0]           b_q, b_d;
  logic                       ei_q, ei_d;
  logic                       li_q, li_d;
  logic                       gi_q, gi_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  cmp_res_t                   res_q, res_d;

  logic [NDIG-1:0][DIG_W-1:0] a_digs;
  logic [NDIG-1:0][DIG_W-1:0] b_digs;
  logic [DIG_W-1:0]           a_dig;
  logic [DIG_W-1:0]           b_dig;
  logic                       signed_msb;
  logic                       dig_gt;
  logic                       dig_lt;

  // Select the digit under the scan pointer.
  always_comb begin
    a_digs = a_q;
    b_digs = b_q;
    a_dig  = a_digs[idx_q];
    b_dig  = b_digs[idx_q];
`ifdef HEX_COMP_SIGNED_EN
    signed_msb = (idx_q == IDX_TOP);
`else
    signed_msb = 1'b0;
`endif
  end

  nibble_cmp u_nib (
    .a_dig      (a_dig),
    .b_dig      (b_dig),
    .signed_msb (signed_msb),
    .gt         (dig_gt),
    .lt         (dig_lt)
  );

  // Next-state and registered-output logic of the scan FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    ei_d    = ei_q;
    li_d    = li_q;
    gi_d    = gi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          ei_d    = bus.ei;
          li_d    = bus.li;
          gi_d    = bus.gi;
          idx_d   = IDX_TOP;
          res_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        unique case (1'b1)
          dig_gt: begin
            res_d   = '{gt: 1'b1, lt: 1'b0, eq: 1'b0};
            done_d  = 1'b1;
            state_d = DONE;
          end
          dig_lt: begin
            res_d   = '{gt: 1'b0, lt: 1'b1, eq: 1'b0};
            done_d  = 1'b1;
            state_d = DONE;
          end
          default: begin
            if (idx_q != '0) begin
              idx_d = idx_q - IDX_W'(1);
            end else begin
              res_d   = resolve_cascade(ei_q, li_q, gi_q);
              done_d  = 1'b1;
              state_d = DONE;
            end
          end
        endcase
      end
      DONE: begin
        busy_d  = 1'b0;
        idx_d   = IDX_TOP;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= IDX_TOP;
      a_q     <= '0;
      b_q     <= '0;
      ei_q    <= 1'b0;
      li_q    <= 1'b0;
      gi_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ei_q    <= ei_d;
      li_q    <= li_d;
      gi_q    <= gi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.gt   = res_q.gt;
  assign bus.lt   = res_q.lt;
  assign bus.eq   = res_q.eq;

endmodule

// File: tb/tb_hex_serial_comparator.sv
// Bench for hex_serial_comparator: directed and random compares
// checked against a whole-word reference model.
module tb_hex_serial_comparator;

  localparam int WIDTH = 16;
  localparam int NDIG  = WIDTH / 4;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  hex_serial_comparator_if #(.WIDTH(WIDTH)) bus ();

  hex_serial_comparator #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result as {gt,lt,eq} and the 1-based position of the deciding digit.
  function automatic void model(input logic [WIDTH-1:0] x,
                                input logic [WIDTH-1:0] y,
                                input logic e, input logic l,
                                input logic g,
                                output logic [2:0] r, output int k);
    bit found;
    found = 0;
    k = NDIG;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (!found && x[4*i +: 4] != y[4*i +: 4]) begin
        k = NDIG - i;
        found = 1;
      end
    end
`ifdef HEX_COMP_SIGNED_EN
    if ($signed(x) > $signed(y))      r = 3'b100;
    else if ($signed(x) < $signed(y)) r = 3'b010;
`else
    if (x > y)      r = 3'b100;
    else if (x < y) r = 3'b010;
`endif
    else if (e) r = 3'b001;
    else if (l) r = 3'b010;
    else if (g) r = 3'b100;
    else        r = 3'b001;
  endfunction

  task automatic run_cmp(input string tag, input logic [WIDTH-1:0] ta,
                         input logic [WIDTH-1:0] tb_v,
                         input logic tei, input logic tli,
                         input logic tgi, input bit hold);
    logic [2:0] exp_res;
    int         k;
    int         got;
    model(ta, tb_v, tei, tli, tgi, exp_res, k);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    bus.ei    = tei;
    bus.li    = tli;
    bus.gi    = tgi;
    @(posedge clk);
    got = 0;
    for (int n = 1; n <= NDIG + 3; n++) begin
      @(negedge clk);
      if (hold) begin
        bus.start = 1'b1;
        bus.a     = WIDTH'($urandom);
        bus.b     = WIDTH'($urandom);
        bus.ei    = 1'($urandom);
        bus.li    = 1'($urandom);
        bus.gi    = 1'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (n == 1) begin
        check({tag, "_busy_c1"}, 32'(bus.busy), 32'd1);
        check({tag, "_res_clr"}, 32'({bus.gt, bus.lt, bus.eq}), 32'd0);
      end
      if (got == 0 && bus.done === 1'b1) got = n;
      if (got != 0) break;
    end
    check({tag, "_done_cyc"}, 32'(got), 32'(k + 1));
    check({tag, "_res"}, 32'({bus.gt, bus.lt, bus.eq}), 32'(exp_res));
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_pulse"}, 32'({bus.busy, bus.done}), 32'd0);
    check({tag, "_hold"}, 32'({bus.gt, bus.lt, bus.eq}), 32'(exp_res));
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.ei    = 1'b0;
    bus.li    = 1'b0;
    bus.gi    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", 32'({bus.busy, bus.done, bus.gt, bus.lt, bus.eq}),
          32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_out", 32'({bus.busy, bus.done, bus.gt, bus.lt, bus.eq}),
          32'd0);

    run_cmp("eq400", 16'd400, 16'd400, 1'b1, 1'b0, 1'b0, 0);
    run_cmp("gt512", 16'd512, 16'd400, 1'b0, 1'b0, 1'b0, 0);
    run_cmp("lt200", 16'd200, 16'd400, 1'b0, 1'b0, 1'b0, 0);
    run_cmp("gt400", 16'd400, 16'd200, 1'b0, 1'b0, 1'b0, 0);
    run_cmp("cas_li", 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 0);
    run_cmp("cas_gi", 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 0);
    run_cmp("cas_0", 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 0);
    run_cmp("cas_eli", 16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0, 0);
    run_cmp("sgn", 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
    run_cmp("lsd", 16'hABC3, 16'hABC4, 1'b0, 1'b0, 1'b1, 0);
    run_cmp("hold", 16'h0190, 16'h0190, 1'b0, 1'b1, 1'b0, 1);
    run_cmp("hold2", 16'h7F00, 16'h7E00, 1'b0, 1'b0, 1'b0, 1);

    for (int it = 0; it < 30; it++) begin
      ra = WIDTH'($urandom);
      rb = ra;
      for (int d = 0; d < NDIG; d++) begin
        if ($urandom_range(0, 2) == 0) rb[4*d +: 4] = 4'($urandom);
      end
      run_cmp($sformatf("rnd%0d", it), ra, rb, 1'($urandom),
              1'($urandom), 1'($urandom), 0);
    end

    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h1234;
    bus.b     = 16'h1234;
    bus.ei    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_scan", 32'({bus.busy, bus.done, bus.gt, bus.lt, bus.eq}),
          32'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("rst_nodone", 32'(bus.done), 32'd0);
    end
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("post_rst", 32'({bus.busy, bus.done}), 32'd0);
    end
    run_cmp("after_rst", 16'h00C8, 16'h0190, 1'b0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
